// File: rtl/sort_pkg.sv
// Shared types and constants for the stream rank sorter.
package sort_pkg;

  typedef enum logic [1:0] {
    LOAD = 2'd0,
    RANK = 2'd1,
    EMIT = 2'd2
  } sort_state_t;

  localparam logic ORDER_ASC  = 1'b0;
  localparam logic ORDER_DESC = 1'b1;

endpackage

// File: rtl/rank_unit.sv
// Combinational rank of one buffered element against the valid part of the frame.
module rank_unit
  import sort_pkg::*;
#(
  parameter  int unsigned N     = 8,
  parameter  int unsigned WIDTH = 8,
  localparam int unsigned IDX_W = $clog2(N)
) (
  input  logic [N-1:0][WIDTH-1:0] i_buf,
  input  logic [IDX_W-1:0]        i_sel,
  input  logic [IDX_W-1:0]        i_last,
  input  logic                    i_desc,
  output logic [IDX_W-1:0]        o_rank
);

  logic [WIDTH-1:0] w_key;
  logic             w_before;

  // Ties count only against earlier arrivals, which makes the resulting order stable.
  always_comb begin
    w_key    = i_buf[i_sel];
    w_before = 1'b0;
    o_rank   = '0;
    for (int j = 0; j < N; j++) begin
      if (IDX_W'(j) <= i_last) begin
        w_before = (i_desc == ORDER_DESC) ? (i_buf[j] > w_key) : (i_buf[j] < w_key);
        if (w_before || ((i_buf[j] == w_key) && (IDX_W'(j) < i_sel))) begin
          o_rank = o_rank + IDX_W'(1);
        end
      end
    end
  end

endmodule

// File: rtl/stream_rank_sort.sv
// Frame-based stable sorter: load a frame, rank one element per cycle, then stream it out.
module stream_rank_sort
  import sort_pkg::*;
#(
  parameter  int unsigned N     = 8,
  parameter  int unsigned WIDTH = 8,
  localparam int unsigned IDX_W = $clog2(N)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  input  logic             in_last,
  input  logic             descend,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic [IDX_W-1:0] out_idx,
  output logic             out_last,
  output logic             busy
);

  sort_state_t             r_state, w_state_d;
  logic [IDX_W-1:0]        r_cnt;
  logic [IDX_W-1:0]        r_last;  // frame length minus one
  logic [IDX_W-1:0]        r_i;
  logic [IDX_W-1:0]        r_k;
  logic                    r_desc;
  logic [N-1:0][WIDTH-1:0] r_buf;
  logic [N-1:0][IDX_W-1:0] r_slot;

  logic                    w_in_fire;
  logic                    w_out_fire;
  logic                    w_frame_end;
  logic [IDX_W-1:0]        w_rank;

  always_comb begin
    w_state_d   = r_state;
    in_ready    = 1'b0;
    out_valid   = 1'b0;
    out_last    = 1'b0;
    out_data    = '0;
    out_idx     = '0;
    busy        = 1'b0;
    w_in_fire   = 1'b0;
    w_out_fire  = 1'b0;
    w_frame_end = 1'b0;
    unique case (r_state)
      LOAD: begin
        in_ready    = 1'b1;
        w_in_fire   = in_valid;
        w_frame_end = in_valid && (in_last || (r_cnt == IDX_W'(N - 1)));
        if (w_frame_end) w_state_d = RANK;
      end
      RANK: begin
        busy = 1'b1;
        if (r_i == r_last) w_state_d = EMIT;
      end
      EMIT: begin
        busy       = 1'b1;
        out_valid  = 1'b1;
        out_idx    = r_slot[r_k];
        out_data   = r_buf[out_idx];
        out_last   = (r_k == r_last);
        w_out_fire = out_ready;
        if (out_ready && out_last) w_state_d = LOAD;
      end
      default: w_state_d = LOAD;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= LOAD;
      r_cnt   <= '0;
      r_last  <= '0;
      r_i     <= '0;
      r_k     <= '0;
      r_desc  <= ORDER_ASC;
    end else begin
      r_state <= w_state_d;
      if (w_in_fire) begin
        r_cnt <= w_frame_end ? '0 : r_cnt + IDX_W'(1);
        // Order is latched on the first beat so later descend changes cannot affect the frame.
        if (r_cnt == '0) r_desc <= descend;
        if (w_frame_end) r_last <= r_cnt;
      end
      if (r_state == RANK) r_i <= (r_i == r_last) ? '0 : r_i + IDX_W'(1);
      if (w_out_fire) r_k <= out_last ? '0 : r_k + IDX_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (w_in_fire) r_buf[r_cnt] <= in_data;
    if (r_state == RANK) r_slot[w_rank] <= r_i;
  end

  rank_unit #(
    .N     (N),
    .WIDTH (WIDTH)
  ) u_rank (
    .i_buf  (r_buf),
    .i_sel  (r_i),
    .i_last (r_last),
    .i_desc (r_desc),
    .o_rank (w_rank)
  );

endmodule

// File: tb/tb_stream_rank_sort.sv
// Directed bench for stream_rank_sort with a scoreboard of expected sorted beats.
module tb_stream_rank_sort;

  localparam int unsigned N     = 6;
  localparam int unsigned WIDTH = 8;
  localparam int unsigned IDX_W = $clog2(N);

  logic             clk = 1'b0;
  logic             rst;
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in_data;
  logic             in_last;
  logic             descend;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out_data;
  logic [IDX_W-1:0] out_idx;
  logic             out_last;
  logic             busy;

  typedef struct {
    logic [WIDTH-1:0] d;
    logic [IDX_W-1:0] idx;
    logic             l;
  } exp_t;

  exp_t exp_q[$];
  int   n_cmp = 0;
  int   n_err = 0;

  stream_rank_sort #(
    .N     (N),
    .WIDTH (WIDTH)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .in_last   (in_last),
    .descend   (descend),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_idx   (out_idx),
    .out_last  (out_last),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    assert (got === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0d expected %0d", tag, got, exp);
    end
  endtask

  // Reference: stable insertion sort of arrival positions.
  task automatic push_exp(input logic [WIDTH-1:0] v[$], input logic ds);
    int   ord[$];
    int   key;
    int   j;
    exp_t e;
    for (int i = 0; i < v.size(); i++) ord.push_back(i);
    for (int i = 1; i < ord.size(); i++) begin
      key = ord[i];
      j   = i - 1;
      while (j >= 0 && (ds ? (v[key] > v[ord[j]]) : (v[key] < v[ord[j]]))) begin
        ord[j+1] = ord[j];
        j--;
      end
      ord[j+1] = key;
    end
    for (int k = 0; k < ord.size(); k++) begin
      e.d   = v[ord[k]];
      e.idx = IDX_W'(ord[k]);
      e.l   = (k == ord.size() - 1);
      exp_q.push_back(e);
    end
  endtask

  task automatic send_frame(input logic [WIDTH-1:0] v[$], input logic use_last, input logic ds,
                            input logic chk_lat, input logic keep_valid);
    int t;
    int n;
    for (int b = 0; b < v.size(); b++) begin
      in_valid = 1'b1;
      in_data  = v[b];
      in_last  = use_last && (b == v.size() - 1);
      descend  = (b == 0) ? ds : ~ds;
      t = 0;
      @(negedge clk);
      while (!in_ready && t < 300) begin
        @(negedge clk);
        t++;
      end
      chk("accept_in_time", 32'(t < 300), 1);
      if (b == 0) begin
        chk("drained_before_accept", 32'(exp_q.size()), 0);
        push_exp(v, ds);
      end
      @(posedge clk);
      #1;
    end
    if (!keep_valid) begin
      in_valid = 1'b0;
      in_last  = 1'b0;
    end
    if (chk_lat) begin
      n = 0;
      while (!out_valid && n < 50) begin
        @(posedge clk);
        #1;
        n++;
      end
      chk("out_valid_latency", 32'(n), 32'(v.size()));
    end
  endtask

  task automatic wait_drain();
    int t;
    t = 0;
    while (exp_q.size() != 0 && t < 500) begin
      @(negedge clk);
      t++;
    end
    chk("drain", 32'(exp_q.size()), 0);
    @(posedge clk);
    #1;
    chk("in_ready_after_last", 32'(in_ready), 1);
    chk("busy_after_last", 32'(busy), 0);
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (!rst && out_valid && out_ready) begin
      chk("out_has_expectation", 32'(exp_q.size() != 0), 1);
      if (exp_q.size() != 0) begin
        e = exp_q.pop_front();
        chk("out_data", 32'(out_data), 32'(e.d));
        chk("out_idx", 32'(out_idx), 32'(e.idx));
        chk("out_last", 32'(out_last), 32'(e.l));
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [WIDTH-1:0] fr[$];
    logic             saw;

    rst       = 1'b1;
    in_valid  = 1'b0;
    in_data   = '0;
    in_last   = 1'b0;
    descend   = 1'b0;
    out_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_in_ready", 32'(in_ready), 1);
    chk("rst_out_valid", 32'(out_valid), 0);
    chk("rst_out_last", 32'(out_last), 0);
    chk("rst_out_data", 32'(out_data), 0);
    chk("rst_out_idx", 32'(out_idx), 0);
    chk("rst_busy", 32'(busy), 0);
    rst = 1'b0;
    @(posedge clk);
    #1;

    // Ascending full frame, with a 3-cycle stall after the second output.
    fr = '{8'd5, 8'd3, 8'd9, 8'd3, 8'd0, 8'd255};
    send_frame(fr, 1'b0, 1'b0, 1'b1, 1'b0);
    @(posedge clk);
    #1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    for (int c = 0; c < 3; c++) begin
      @(posedge clk);
      #1;
      chk("stall_out_valid", 32'(out_valid), 1);
      chk("stall_out_data", 32'(out_data), 32'(exp_q[0].d));
      chk("stall_out_idx", 32'(out_idx), 32'(exp_q[0].idx));
      chk("stall_in_ready", 32'(in_ready), 0);
    end
    out_ready = 1'b1;
    wait_drain();

    // Descending, same data.
    send_frame(fr, 1'b0, 1'b1, 1'b1, 1'b0);
    wait_drain();

    // Partial frame terminated by in_last.
    fr = '{8'd7, 8'd7, 8'd1};
    send_frame(fr, 1'b1, 1'b0, 1'b1, 1'b0);
    wait_drain();

    // Single-element frame.
    fr = '{8'd42};
    send_frame(fr, 1'b1, 1'b1, 1'b1, 1'b0);
    wait_drain();

    // Reset pulsed while ranking discards the frame.
    fr = '{8'd9, 8'd4, 8'd6};
    send_frame(fr, 1'b1, 1'b0, 1'b0, 1'b0);
    chk("busy_in_rank", 32'(busy), 1);
    rst = 1'b1;
    #2;
    rst = 1'b0;
    #1;
    chk("mid_rst_in_ready", 32'(in_ready), 1);
    chk("mid_rst_busy", 32'(busy), 0);
    exp_q.delete();
    saw = 1'b0;
    for (int c = 0; c < 20; c++) begin
      @(posedge clk);
      #1;
      saw = saw | out_valid;
    end
    chk("no_out_after_rst", 32'(saw), 0);
    fr = '{8'd2, 8'd1};
    send_frame(fr, 1'b1, 1'b0, 1'b1, 1'b0);
    wait_drain();

    // Back-to-back frames with in_valid held high throughout.
    fr = '{8'd4, 8'd8, 8'd1, 8'd8};
    send_frame(fr, 1'b1, 1'b1, 1'b0, 1'b1);
    fr = '{8'd6, 8'd6, 8'd200, 8'd6, 8'd6, 8'd2};
    send_frame(fr, 1'b0, 1'b0, 1'b0, 1'b0);
    wait_drain();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
